// File: rtl/cardinal_pkg.sv
`default_nettype none
// ============================================================================
// cardinal_pkg : shared constants and encodings for the cardinal fetch stage
// Revision     : 1.0
// ============================================================================
package cardinal_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  // End-of-program marker; fetch freezes after accepting this word.
  localparam logic [0:INSTR_W-1] NOP_HALT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_RESET  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_HOLD   = 2'd2,
    PC_SEQ    = 2'd3
  } pc_sel_e;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/cardinal_pc_next.sv
`default_nettype none
// ============================================================================
// cardinal_pc_next : combinational next-PC priority mux and sequential adder
// Revision         : 1.0
// ============================================================================
module cardinal_pc_next
  import cardinal_pkg::*;
#(
  parameter logic [0:ADDR_W-1] RESET_PC     = 32'h0000_0000,
  parameter int unsigned       PC_STEP      = 4,
  parameter bit                HALT_ON_ZERO = 1'b1
) (
  input  logic                i_reset,
  input  logic                i_branch_taken,
  input  logic [0:ADDR_W-1]   i_branch_target,
  input  logic                i_halted,
  input  logic                i_stall,
  input  logic [0:INSTR_W-1]  i_instr,
  input  logic [0:ADDR_W-1]   i_pc,
  output pc_sel_e             o_sel,
  output logic [0:ADDR_W-1]   o_pc_next,
  output logic                o_halt_hit
);

  logic [0:ADDR_W-1] w_seq_pc;
  logic              w_is_nop;

  assign w_seq_pc = i_pc + ADDR_W'(PC_STEP);
  assign w_is_nop = HALT_ON_ZERO && (i_instr == NOP_HALT);

  always_comb begin
    o_sel      = PC_SEQ;
    o_pc_next  = w_seq_pc;
    o_halt_hit = 1'b0;
    if (i_reset) begin
      o_sel     = PC_RESET;
      o_pc_next = RESET_PC;
    end else if (i_branch_taken) begin
      // Branch targets are word aligned by dropping the two byte-offset bits.
      o_sel     = PC_BRANCH;
      o_pc_next = i_branch_target & 32'hFFFF_FFFC;
    end else if (i_halted || i_stall) begin
      o_sel     = PC_HOLD;
      o_pc_next = i_pc;
    end else if (w_is_nop) begin
      o_pc_next  = i_pc;
      o_halt_hit = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cardinal_fetch_stage.sv
`default_nettype none
// ============================================================================
// cardinal_fetch_stage : program counter, IF/ID register and halt-on-NOP FSM
// Revision             : 1.0
// ============================================================================
module cardinal_fetch_stage
  import cardinal_pkg::*;
#(
  parameter logic [0:ADDR_W-1] RESET_PC     = 32'h0000_0000,
  parameter int unsigned       PC_STEP      = 4,
  parameter bit                HALT_ON_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [0:INSTR_W-1]  instruction,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [0:ADDR_W-1]   branch_target,
  output logic [0:ADDR_W-1]   pc,
  output logic [0:INSTR_W-1]  if_id_instr,
  output logic [0:ADDR_W-1]   if_id_pc,
  output logic                if_id_valid,
  output logic                halted,
  output logic [0:31]         fetch_count
);

  fetch_state_e       r_state;
  logic [0:ADDR_W-1]  r_pc;
  logic [0:INSTR_W-1] r_instr;
  logic [0:ADDR_W-1]  r_ipc;
  logic               r_valid;
  logic [0:31]        r_count;

  pc_sel_e            w_sel;
  logic [0:ADDR_W-1]  w_pc_next;
  logic               w_halt_hit;

  cardinal_pc_next #(
    .RESET_PC     (RESET_PC),
    .PC_STEP      (PC_STEP),
    .HALT_ON_ZERO (HALT_ON_ZERO)
  ) u_pc_next (
    .i_reset         (reset),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_halted        (r_state == ST_HALT),
    .i_stall         (stall),
    .i_instr         (instruction),
    .i_pc            (r_pc),
    .o_sel           (w_sel),
    .o_pc_next       (w_pc_next),
    .o_halt_hit      (w_halt_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_ipc   <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      case (w_sel)
        PC_BRANCH: begin
          // Flush: the word fetched this cycle is on the wrong path.
          r_pc    <= w_pc_next;
          r_instr <= '0;
          r_valid <= 1'b0;
          r_state <= ST_RUN;
        end
        PC_HOLD: begin
          if (r_state == ST_HALT) begin
            r_valid <= 1'b0;
          end
        end
        PC_SEQ: begin
          r_pc    <= w_pc_next;
          r_instr <= instruction;
          r_ipc   <= r_pc;
          r_valid <= 1'b1;
          r_count <= r_count + 32'd1;
          if (w_halt_hit) begin
            r_state <= ST_HALT;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc          = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc    = r_ipc;
  assign if_id_valid = r_valid;
  assign halted      = (r_state == ST_HALT);
  assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cardinal_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_cardinal_fetch_stage : directed table plus randomized model comparison
// Revision                : 1.0
// ============================================================================
module tb_cardinal_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
  } mstate_t;

  typedef struct {
    logic        rst, stl, br;
    logic [31:0] tgt;
    logic [31:0] pc, instr, ipc;
    logic        v, h;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] mem [0:511];

  logic [31:0] pc1, instr1, ipc1, cnt1, imem1;
  logic        valid1, halted1;
  logic [31:0] pc2, instr2, ipc2, cnt2, imem2;
  logic        valid2, halted2;

  int total = 0;
  int bad   = 0;

  mstate_t m1, m2;
  vec_t    tbl[$];

  always #5 clk = ~clk;

  assign imem1 = mem[pc1[10:2]];
  assign imem2 = mem[pc2[10:2]];

  cardinal_fetch_stage #(.RESET_PC(32'h0), .PC_STEP(4), .HALT_ON_ZERO(1'b1)) dut1 (
    .clk(clk), .reset(reset), .instruction(imem1), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc1), .if_id_instr(instr1), .if_id_pc(ipc1), .if_id_valid(valid1),
    .halted(halted1), .fetch_count(cnt1)
  );

  cardinal_fetch_stage #(.RESET_PC(32'h0), .PC_STEP(4), .HALT_ON_ZERO(1'b0)) dut2 (
    .clk(clk), .reset(reset), .instruction(imem2), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc2), .if_id_instr(instr2), .if_id_pc(ipc2), .if_id_valid(valid2),
    .halted(halted2), .fetch_count(cnt2)
  );

  // Reference behaviour: one clock edge of the fetch stage, straight from the rules.
  function automatic mstate_t nxt(mstate_t s, logic r, logic st, logic b,
                                  logic [31:0] t, bit hoz);
    mstate_t     n = s;
    logic [31:0] w = mem[(s.pc >> 2) & 32'd511];
    if (r) begin
      n = '{pc: 32'h0, instr: 32'h0, ipc: 32'h0, valid: 1'b0, halted: 1'b0, cnt: 32'h0};
    end else if (b) begin
      n.pc     = t & ~32'd3;
      n.instr  = 32'h0;
      n.valid  = 1'b0;
      n.halted = 1'b0;
    end else if (s.halted) begin
      n.valid = 1'b0;
    end else if (!st) begin
      n.instr = w;
      n.ipc   = s.pc;
      n.valid = 1'b1;
      n.cnt   = s.cnt + 32'd1;
      if (hoz && w == 32'h0) n.halted = 1'b1;
      else                   n.pc     = s.pc + 32'd4;
    end
    return n;
  endfunction

  function automatic vec_t v(logic r, logic s, logic b, logic [31:0] t, logic [31:0] p,
                             logic [31:0] i, logic [31:0] ip, logic vv, logic h,
                             logic [31:0] c);
    vec_t x;
    x.rst = r; x.stl = s; x.br = b; x.tgt = t;
    x.pc = p; x.instr = i; x.ipc = ip; x.v = vv; x.h = h; x.cnt = c;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_model(input string tag, input mstate_t m, input logic [31:0] p,
                           input logic [31:0] i, input logic [31:0] ip, input logic vv,
                           input logic h, input logic [31:0] c);
    chk({tag, ".pc"},          p,  m.pc);
    chk({tag, ".if_id_instr"}, i,  m.instr);
    chk({tag, ".if_id_pc"},    ip, m.ipc);
    chk({tag, ".if_id_valid"}, {31'b0, vv}, {31'b0, m.valid});
    chk({tag, ".halted"},      {31'b0, h},  {31'b0, m.halted});
    chk({tag, ".fetch_count"}, c,  m.cnt);
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    m1 = nxt(m1, r, s, b, t, 1'b1);
    m2 = nxt(m2, r, s, b, t, 1'b0);
    #1;
    chk_model("model1", m1, pc1, instr1, ipc1, valid1, halted1, cnt1);
    chk_model("model2", m2, pc2, instr2, ipc2, valid2, halted2, cnt2);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h1111_1111 * (i + 1);
    mem[4] = 32'h0;
    m1 = '{pc: 32'h0, instr: 32'h0, ipc: 32'h0, valid: 1'b0, halted: 1'b0, cnt: 32'h0};
    m2 = m1;

    // rst stl br target | pc instr if_id_pc valid halted count
    for (int i = 0; i < 5; i++) tbl.push_back(v(1,0,0,32'h0, 32'h0,32'h0,32'h0,0,0,0));
    tbl.push_back(v(0,0,0,32'h0,        32'h4,       32'h11111111, 32'h0,        1,0,1));
    tbl.push_back(v(0,0,0,32'h0,        32'h8,       32'h22222222, 32'h4,        1,0,2));
    tbl.push_back(v(0,1,0,32'h0,        32'h8,       32'h22222222, 32'h4,        1,0,2));
    tbl.push_back(v(0,1,0,32'h0,        32'h8,       32'h22222222, 32'h4,        1,0,2));
    tbl.push_back(v(0,0,0,32'h0,        32'hC,       32'h33333333, 32'h8,        1,0,3));
    tbl.push_back(v(0,0,1,32'h43,       32'h40,      32'h0,        32'h8,        0,0,3));
    tbl.push_back(v(0,0,0,32'h0,        32'h44,      32'h22222221, 32'h40,       1,0,4));
    tbl.push_back(v(0,1,1,32'h43,       32'h40,      32'h0,        32'h40,       0,0,4));
    tbl.push_back(v(0,0,0,32'h0,        32'h44,      32'h22222221, 32'h40,       1,0,5));
    tbl.push_back(v(0,0,1,32'h10,       32'h10,      32'h0,        32'h40,       0,0,5));
    tbl.push_back(v(0,0,0,32'h0,        32'h10,      32'h0,        32'h10,       1,1,6));
    tbl.push_back(v(0,0,0,32'h0,        32'h10,      32'h0,        32'h10,       0,1,6));
    tbl.push_back(v(0,1,0,32'h0,        32'h10,      32'h0,        32'h10,       0,1,6));
    tbl.push_back(v(0,0,1,32'h20,       32'h20,      32'h0,        32'h10,       0,0,6));
    tbl.push_back(v(0,0,0,32'h0,        32'h24,      32'h99999999, 32'h20,       1,0,7));
    tbl.push_back(v(0,0,1,32'hFFFFFFFC, 32'hFFFFFFFC,32'h0,        32'h20,       0,0,7));
    tbl.push_back(v(0,0,0,32'h0,        32'h0,       32'h22222200, 32'hFFFFFFFC, 1,0,8));
    tbl.push_back(v(0,0,1,32'h10,       32'h10,      32'h0,        32'hFFFFFFFC, 0,0,8));
    tbl.push_back(v(0,0,0,32'h0,        32'h10,      32'h0,        32'h10,       1,1,9));
    tbl.push_back(v(1,1,0,32'h0,        32'h0,       32'h0,        32'h0,        0,0,0));
    tbl.push_back(v(0,0,0,32'h0,        32'h4,       32'h11111111, 32'h0,        1,0,1));

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].stl, tbl[k].br, tbl[k].tgt);
      chk("tbl.pc",          pc1,    tbl[k].pc);
      chk("tbl.if_id_instr", instr1, tbl[k].instr);
      chk("tbl.if_id_pc",    ipc1,   tbl[k].ipc);
      chk("tbl.if_id_valid", {31'b0, valid1},  {31'b0, tbl[k].v});
      chk("tbl.halted",      {31'b0, halted1}, {31'b0, tbl[k].h});
      chk("tbl.fetch_count", cnt1,   tbl[k].cnt);
      if (k == 15) begin
        // Same NOP fetch with halting disabled just advances.
        chk("nohalt.pc",     pc2, 32'h14);
        chk("nohalt.halted", {31'b0, halted2}, 32'h0);
      end
    end

    for (int i = 0; i < 512; i++)
      mem[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 600; n++) begin
      logic        r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2047));
      step(r, s, b, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
